// File: rtl/mul_ctrl_dp.sv
// Repeated-addition multiplier: control FSM and accumulator datapath that
// iterates with an external registered zero-detect stage on cnt_out.
module mul_ctrl_dp #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    input  logic               eqz,
    input  logic               neqz,
    output logic [WIDTH-1:0]   cnt_out,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               done,
    output logic               err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_TEST = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic [WIDTH-1:0]   a_r, a_s;
    logic [WIDTH-1:0]   b_r, b_s;
    logic [2*WIDTH-1:0] p_r, p_s;
    logic               err_r, err_s;
    logic               busy_r, done_r;

    // Next-state and datapath update for every control state
    always_comb begin
        state_s = state_r;
        a_s     = a_r;
        b_s     = b_r;
        p_s     = p_r;
        err_s   = err_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                // DONE also accepts start so back-to-back operations have no bubble
                if (start) begin
                    a_s     = a_in;
                    b_s     = b_in;
                    p_s     = {(2*WIDTH){1'b0}};
                    err_s   = 1'b0;
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                state_s = ST_TEST;
            end
            ST_TEST: begin
                if (eqz == neqz) begin
                    err_s   = 1'b1;
                    state_s = ST_DONE;
                end else if (eqz) begin
                    state_s = ST_DONE;
                end else begin
                    p_s     = p_r + {{WIDTH{1'b0}}, a_r};
                    b_s     = b_r - {{(WIDTH-1){1'b0}}, 1'b1};
                    state_s = ST_WAIT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            p_r     <= {(2*WIDTH){1'b0}};
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            a_r     <= a_s;
            b_r     <= b_s;
            p_r     <= p_s;
            err_r   <= err_s;
            busy_r  <= (state_s != ST_IDLE);
            done_r  <= (state_s == ST_DONE);
        end
    end

    assign cnt_out = b_r;
    assign product = p_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign err     = err_r;

endmodule

// File: tb/tb_mul_ctrl_dp.sv
// Self-checking bench for mul_ctrl_dp with a behavioural zero-detect stage,
// a vector table, random operations against a*b, and multi-cycle corner cases.
module tb_mul_ctrl_dp;

    localparam int W = 16;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   a_in;
    logic [W-1:0]   b_in;
    logic           eqz;
    logic           neqz;
    logic [W-1:0]   cnt_out;
    logic [2*W-1:0] product;
    logic           busy;
    logic           done;
    logic           err;

    logic zd_eqz, zd_neqz, fault_en;
    int   total, bad;

    mul_ctrl_dp #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
        .eqz(eqz), .neqz(neqz), .cnt_out(cnt_out), .product(product),
        .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Zero-detect stage model: one-cycle registered flags of cnt_out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zd_eqz  <= 1'b1;
            zd_neqz <= 1'b0;
        end else begin
            zd_eqz  <= (cnt_out == 16'd0);
            zd_neqz <= (cnt_out != 16'd0);
        end
    end

    assign eqz  = (fault_en && cnt_out == 16'd3) ? 1'b1 : zd_eqz;
    assign neqz = (fault_en && cnt_out == 16'd3) ? 1'b1 : zd_neqz;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] p;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation from IDLE; expected product and latency come from the caller/model
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp_p, input logic exp_err);
        int cnt;
        int exp_lat;
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        tick();
        start = 1'b0;
        a_in  = $urandom;
        b_in  = $urandom;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("cnt_loaded", {16'd0, cnt_out}, {16'd0, b});
        cnt = 0;
        while (!done && cnt < 200) begin
            tick();
            cnt++;
        end
        exp_lat = exp_err ? cnt : 2 + 2 * int'(b);
        chk("latency", cnt, exp_lat);
        chk("product", product, exp_p);
        chk("err", {31'd0, err}, {31'd0, exp_err});
        chk("busy_at_done", {31'd0, busy}, 32'd1);
        tick();
        chk("done_pulse_ends", {31'd0, done}, 32'd0);
        chk("busy_falls", {31'd0, busy}, 32'd0);
        chk("product_holds", product, exp_p);
    endtask

    initial begin
        int cnt;
        logic [W-1:0] ra, rb;
        total    = 0;
        bad      = 0;
        fault_en = 1'b0;
        start    = 1'b0;
        a_in     = 16'd0;
        b_in     = 16'd0;
        rst_n    = 1'b0;

        vecs[0] = '{a: 16'd7,      b: 16'd5, p: 32'd35};
        vecs[1] = '{a: 16'h1234,   b: 16'd0, p: 32'd0};
        vecs[2] = '{a: 16'hFFFF,   b: 16'd3, p: 32'h0002_FFFD};
        vecs[3] = '{a: 16'd0,      b: 16'd4, p: 32'd0};
        vecs[4] = '{a: 16'd1,      b: 16'd1, p: 32'd1};
        vecs[5] = '{a: 16'hFFFF,   b: 16'd1, p: 32'h0000_FFFF};

        #12;
        chk("rst_product", product, 32'd0);
        chk("rst_cnt", {16'd0, cnt_out}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].p, 1'b0);
        end

        // Random operations checked against plain multiplication
        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom);
            rb = W'($urandom_range(0, 12));
            run_op(ra, rb, {16'd0, ra} * {16'd0, rb}, 1'b0);
        end

        // Start held high: second operation starts right at the DONE edge
        start = 1'b1;
        a_in  = 16'd6;
        b_in  = 16'd4;
        tick();
        a_in = 16'd2;
        b_in = 16'd3;
        cnt  = 0;
        while (!done && cnt < 200) begin
            tick();
            cnt++;
        end
        chk("hold_first_lat", cnt, 32'd10);
        chk("hold_first_product", product, 32'd24);
        tick();
        start = 1'b0;
        chk("hold_second_busy", {31'd0, busy}, 32'd1);
        chk("hold_second_done_low", {31'd0, done}, 32'd0);
        chk("hold_second_cnt", {16'd0, cnt_out}, 32'd3);
        cnt = 0;
        while (!done && cnt < 200) begin
            tick();
            cnt++;
        end
        chk("hold_second_lat", cnt, 32'd8);
        chk("hold_second_product", product, 32'd6);
        tick();
        chk("hold_idle", {31'd0, busy}, 32'd0);

        // Reset during the iteration where B=2
        start = 1'b1;
        a_in  = 16'd4;
        b_in  = 16'd5;
        tick();
        start = 1'b0;
        cnt   = 0;
        while (cnt_out != 16'd2 && cnt < 50) begin
            tick();
            cnt++;
        end
        chk("reach_b2", {31'd0, cnt_out == 16'd2}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_product", product, 32'd0);
        chk("midrst_cnt", {16'd0, cnt_out}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_err", {31'd0, err}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("midrst_no_done", {31'd0, done}, 32'd0);
        end
        rst_n = 1'b1;
        run_op(16'd3, 16'd3, 32'd9, 1'b0);

        // Flag fault while B=3: partial sum 5+5 then err
        fault_en = 1'b1;
        run_op(16'd5, 16'd5, 32'd10, 1'b1);
        chk("fault_cnt_holds", {16'd0, cnt_out}, 32'd3);
        fault_en = 1'b0;
        run_op(16'd2, 16'd2, 32'd4, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
